// File: rtl/blockram_access_ctrl_pkg.sv
// Shared types for the blockram access controller: sequencer state, read-client count and client id.
package blockram_access_ctrl_pkg;

    localparam int NUM_CLIENTS = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_t;

    typedef logic client_id_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter. The pick is computed every cycle; the grant only when enabled,
// and last_grant advances only on an actual grant so a suppressed client keeps its turn.
module rr_arbiter_2
    import blockram_access_ctrl_pkg::*;
(
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic [1:0] req_in,
    input  logic       grant_en_in,
    output logic       pick_valid_out,
    output client_id_t pick_id_out,
    output logic [1:0] grant_out
);

    client_id_t last_grant_reg;

    always_comb begin
        pick_valid_out = 1'b1;
        pick_id_out    = 1'b0;
        case (req_in)
            2'b01:   pick_id_out = 1'b0;
            2'b10:   pick_id_out = 1'b1;
            2'b11:   pick_id_out = ~last_grant_reg;
            default: pick_valid_out = 1'b0;
        endcase
    end

    always_comb begin
        grant_out = 2'b00;
        if (pick_valid_out && grant_en_in) begin
            grant_out[pick_id_out] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            last_grant_reg <= 1'b1;
        end else if (pick_valid_out && grant_en_in) begin
            last_grant_reg <= pick_id_out;
        end
    end

endmodule

// File: rtl/blockram_access_ctrl.sv
// Init sweep, read arbitration and write pass-through in front of one dual-port tag RAM.
// Optional macro BLOCKRAM_CTRL_RW_BYPASS_EN: same-set read/write are granted together and the read returns the new data.
module blockram_access_ctrl
    import blockram_access_ctrl_pkg::*;
#(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = 6,
    parameter logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] INIT_ENTRY = '0
) (
    input  logic                                   clk_in,
    input  logic                                   reset_in,
    input  logic [1:0]                             rd_valid_in,
    input  logic [2*SET_PTR_WIDTH_IN_BITS-1:0]     rd_set_addr_in,
    output logic [1:0]                             rd_ready_out,
    output logic [1:0]                             rd_resp_valid_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   rd_resp_entry_out,
    input  logic                                   wr_valid_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       wr_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   wr_entry_in,
    output logic                                   wr_ready_out,
    output logic                                   wr_resp_valid_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   wr_evict_entry_out,
    output logic                                   init_done_out,
    output logic                                   ram_read_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_read_set_addr_out,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   ram_read_entry_in,
    output logic                                   ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_write_set_addr_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   ram_write_entry_out,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   ram_evict_entry_in
);

    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);

    ctrl_state_t                      state_reg, state_next;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] init_cnt_reg, init_cnt_next;
    logic [1:0]                       rd_resp_valid_reg;
    logic                             wr_resp_valid_reg;

    logic [SET_PTR_WIDTH_IN_BITS-1:0] rd_addr [NUM_CLIENTS];
    logic                             in_init, in_run;
    logic                             pick_valid, addr_clash, grant_en, wr_grant;
    client_id_t                       pick_id;
    logic [1:0]                       rd_grant;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] pick_addr;

    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_rd_addr
            assign rd_addr[gi] = rd_set_addr_in[gi*SET_PTR_WIDTH_IN_BITS +: SET_PTR_WIDTH_IN_BITS];
        end
    endgenerate

    assign in_init    = (state_reg == ST_INIT);
    assign in_run     = (state_reg == ST_RUN);
    assign pick_addr  = rd_addr[pick_id];
    assign addr_clash = wr_valid_in && pick_valid && (pick_addr == wr_set_addr_in);
    assign wr_grant   = in_run && wr_valid_in;

`ifdef BLOCKRAM_CTRL_RW_BYPASS_EN
    assign grant_en = in_run;
`else
    // The RAM would hand back stale data, so the write wins and the read client retries.
    assign grant_en = in_run && !addr_clash;
`endif

    rr_arbiter_2 u_arb (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .req_in         (rd_valid_in),
        .grant_en_in    (grant_en),
        .pick_valid_out (pick_valid),
        .pick_id_out    (pick_id),
        .grant_out      (rd_grant)
    );

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        case (state_reg)
            ST_INIT: begin
                if (init_cnt_reg == LAST_SET) begin
                    state_next    = ST_RUN;
                    init_cnt_next = '0;
                end else begin
                    init_cnt_next = init_cnt_reg + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // The RAM only commits a write while its read port is enabled, so every write also enables the read.
    always_comb begin
        ram_read_en_out        = !reset_in && (in_init || wr_grant || (|rd_grant));
        ram_write_en_out       = !reset_in && (in_init || wr_grant);
        ram_read_set_addr_out  = in_init ? init_cnt_reg : ((|rd_grant) ? pick_addr : wr_set_addr_in);
        ram_write_set_addr_out = in_init ? init_cnt_reg : wr_set_addr_in;
        ram_write_entry_out    = in_init ? INIT_ENTRY : wr_entry_in;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_reg         <= ST_INIT;
            init_cnt_reg      <= '0;
            rd_resp_valid_reg <= 2'b00;
            wr_resp_valid_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            init_cnt_reg      <= init_cnt_next;
            rd_resp_valid_reg <= rd_grant;
            wr_resp_valid_reg <= wr_grant;
        end
    end

    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] rd_data;

`ifdef BLOCKRAM_CTRL_RW_BYPASS_EN
    logic                                 byp_hit_reg;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] byp_data_reg;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            byp_hit_reg  <= 1'b0;
            byp_data_reg <= '0;
        end else begin
            byp_hit_reg <= addr_clash && (|rd_grant);
            if (wr_grant) begin
                byp_data_reg <= wr_entry_in;
            end
        end
    end

    assign rd_data = byp_hit_reg ? byp_data_reg : ram_read_entry_in;
`else
    assign rd_data = ram_read_entry_in;
`endif

    assign rd_ready_out       = rd_grant;
    assign wr_ready_out       = wr_grant;
    assign init_done_out      = in_run;
    assign rd_resp_valid_out  = rd_resp_valid_reg;
    assign wr_resp_valid_out  = wr_resp_valid_reg;
    assign rd_resp_entry_out  = (|rd_resp_valid_reg) ? rd_data : '0;
    assign wr_evict_entry_out = wr_resp_valid_reg ? ram_evict_entry_in : '0;

endmodule

// File: tb/tb_blockram_access_ctrl.sv
// Directed bench for blockram_access_ctrl with a behavioural dual-port RAM (stale read on same-set write).
module tb_blockram_access_ctrl;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [1:0]  rd_valid_in;
    logic [11:0] rd_set_addr_in;
    logic [1:0]  rd_ready_out;
    logic [1:0]  rd_resp_valid_out;
    logic [63:0] rd_resp_entry_out;
    logic        wr_valid_in;
    logic [5:0]  wr_set_addr_in;
    logic [63:0] wr_entry_in;
    logic        wr_ready_out;
    logic        wr_resp_valid_out;
    logic [63:0] wr_evict_entry_out;
    logic        init_done_out;
    logic        ram_read_en_out;
    logic [5:0]  ram_read_set_addr_out;
    logic [63:0] ram_read_entry_in = '0;
    logic        ram_write_en_out;
    logic [5:0]  ram_write_set_addr_out;
    logic [63:0] ram_write_entry_out;
    logic [63:0] ram_evict_entry_in = '0;

    int errors = 0;
    int checks = 0;
    int init_wr_resp_cnt = 0;
    int n;

    always #5 clk_in = ~clk_in;

    blockram_access_ctrl dut (
        .clk_in                 (clk_in),
        .reset_in               (reset_in),
        .rd_valid_in            (rd_valid_in),
        .rd_set_addr_in         (rd_set_addr_in),
        .rd_ready_out           (rd_ready_out),
        .rd_resp_valid_out      (rd_resp_valid_out),
        .rd_resp_entry_out      (rd_resp_entry_out),
        .wr_valid_in            (wr_valid_in),
        .wr_set_addr_in         (wr_set_addr_in),
        .wr_entry_in            (wr_entry_in),
        .wr_ready_out           (wr_ready_out),
        .wr_resp_valid_out      (wr_resp_valid_out),
        .wr_evict_entry_out     (wr_evict_entry_out),
        .init_done_out          (init_done_out),
        .ram_read_en_out        (ram_read_en_out),
        .ram_read_set_addr_out  (ram_read_set_addr_out),
        .ram_read_entry_in      (ram_read_entry_in),
        .ram_write_en_out       (ram_write_en_out),
        .ram_write_set_addr_out (ram_write_set_addr_out),
        .ram_write_entry_out    (ram_write_entry_out),
        .ram_evict_entry_in     (ram_evict_entry_in)
    );

    // RAM model: all activity gated by read enable; a same-set read returns the old contents.
    logic [63:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
    end
    always @(posedge clk_in) begin
        if (ram_read_en_out) begin
            ram_read_entry_in  <= mem[ram_read_set_addr_out];
            ram_evict_entry_in <= mem[ram_write_set_addr_out];
            if (ram_write_en_out) mem[ram_write_set_addr_out] <= ram_write_entry_out;
        end
    end

    always @(negedge clk_in) begin
        if (!init_done_out && wr_resp_valid_out) init_wr_resp_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [63:0] data, input logic [63:0] exp_evict);
        @(negedge clk_in);
        wr_valid_in = 1'b1; wr_set_addr_in = addr; wr_entry_in = data;
        #1 check("wr_ready", 64'(wr_ready_out), 64'd1);
        @(posedge clk_in); #1;
        check("wr_resp_valid", 64'(wr_resp_valid_out), 64'd1);
        check("wr_evict", wr_evict_entry_out, exp_evict);
        $display("write set %0d data=%0h evict=%0h", addr, data, wr_evict_entry_out);
        wr_valid_in = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [63:0] exp_d;
        reset_in = 1'b1; rd_valid_in = 2'b00; rd_set_addr_in = '0;
        wr_valid_in = 1'b0; wr_set_addr_in = '0; wr_entry_in = '0;
        repeat (2) @(negedge clk_in);
        #1;
        check("rst_init_done", 64'(init_done_out), 64'd0);
        check("rst_rd_resp", 64'(rd_resp_valid_out), 64'd0);
        check("rst_wr_resp", 64'(wr_resp_valid_out), 64'd0);
        check("rst_ram_wr_en", 64'(ram_write_en_out), 64'd0);

        // Init sweep: requests are ignored, set 0 written first, done after 64 edges.
        @(negedge clk_in);
        reset_in = 1'b0;
        rd_valid_in = 2'b11; wr_valid_in = 1'b1;
        #1;
        check("init_rd_ready", 64'(rd_ready_out), 64'd0);
        check("init_wr_ready", 64'(wr_ready_out), 64'd0);
        check("init_first_set", 64'(ram_write_set_addr_out), 64'd0);
        check("init_wr_en", 64'(ram_write_en_out), 64'd1);
        rd_valid_in = 2'b00; wr_valid_in = 1'b0;
        n = 0;
        while (!init_done_out && n < 200) begin
            @(posedge clk_in); #1; n++;
        end
        check("init_cycles", 64'(n), 64'd64);
        check("init_no_wr_resp", 64'(init_wr_resp_cnt), 64'd0);
        $display("init done after %0d cycles", n);

        do_write(6'd3, 64'hAA, 64'h0);
        do_write(6'd3, 64'hBB, 64'hAA);
        do_write(6'd5, 64'h55, 64'h0);
        do_write(6'd9, 64'h99, 64'h0);
        do_write(6'd7, 64'h11, 64'h0);

        // Both clients continuously: grants alternate 0,1,0,1.
        @(negedge clk_in);
        rd_valid_in = 2'b11; rd_set_addr_in = {6'd9, 6'd5};
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (i % 2 == 0) ? 64'h55 : 64'h99;
            #1 check("rr_grant", 64'(rd_ready_out), 64'(exp_g));
            @(posedge clk_in); #1;
            check("rr_resp_valid", 64'(rd_resp_valid_out), 64'(exp_g));
            check("rr_resp_data", rd_resp_entry_out, exp_d);
            $display("read grant=%b resp=%b data=%0h", exp_g, rd_resp_valid_out, rd_resp_entry_out);
            @(negedge clk_in);
        end
        rd_valid_in = 2'b00;

        // Set 63 was swept to INIT_ENTRY.
        @(negedge clk_in);
        rd_valid_in = 2'b01; rd_set_addr_in = {6'd0, 6'd63};
        #1 check("rd63_grant", 64'(rd_ready_out), 64'd1);
        @(posedge clk_in); #1;
        rd_valid_in = 2'b00;
        check("rd63_resp_valid", 64'(rd_resp_valid_out), 64'd1);
        check("rd63_data", rd_resp_entry_out, 64'h0);
        $display("read set 63 data=%0h", rd_resp_entry_out);

        // Same-cycle read and write of set 7 (old 0x11, new 0x22).
        @(negedge clk_in);
        rd_valid_in = 2'b01; rd_set_addr_in = {6'd0, 6'd7};
        wr_valid_in = 1'b1; wr_set_addr_in = 6'd7; wr_entry_in = 64'h22;
        #1 check("coll_wr_ready", 64'(wr_ready_out), 64'd1);
`ifdef BLOCKRAM_CTRL_RW_BYPASS_EN
        check("coll_rd_ready", 64'(rd_ready_out), 64'd1);
        @(posedge clk_in); #1;
        wr_valid_in = 1'b0; rd_valid_in = 2'b00;
        check("coll_evict", wr_evict_entry_out, 64'h11);
        check("coll_resp_valid", 64'(rd_resp_valid_out), 64'd1);
        check("coll_data", rd_resp_entry_out, 64'h22);
`else
        check("coll_rd_stall", 64'(rd_ready_out), 64'd0);
        @(posedge clk_in); #1;
        wr_valid_in = 1'b0;
        check("coll_evict", wr_evict_entry_out, 64'h11);
        check("coll_no_resp", 64'(rd_resp_valid_out), 64'd0);
        @(negedge clk_in);
        #1 check("coll_retry_grant", 64'(rd_ready_out), 64'd1);
        @(posedge clk_in); #1;
        rd_valid_in = 2'b00;
        check("coll_resp_valid", 64'(rd_resp_valid_out), 64'd1);
        check("coll_data", rd_resp_entry_out, 64'h22);
`endif
        $display("collision set 7 read data=%0h", rd_resp_entry_out);

        // Write set 10 at T, read it at T+1 with no stall.
        do_write(6'd10, 64'h1010, 64'h0);
        rd_valid_in = 2'b10; rd_set_addr_in = {6'd10, 6'd0};
        #1 check("raw_grant", 64'(rd_ready_out), 64'd2);
        @(posedge clk_in); #1;
        rd_valid_in = 2'b00;
        check("raw_resp_valid", 64'(rd_resp_valid_out), 64'd2);
        check("raw_data", rd_resp_entry_out, 64'h1010);
        $display("read set 10 after write data=%0h", rd_resp_entry_out);

        // Reset right at the grant edge: no response, sweep restarts at set 0.
        @(negedge clk_in);
        rd_valid_in = 2'b01; rd_set_addr_in = {6'd0, 6'd5};
        #1 check("rst_rd_grant", 64'(rd_ready_out), 64'd1);
        @(posedge clk_in);
        reset_in = 1'b1; rd_valid_in = 2'b00;
        #1;
        check("rst_mid_no_resp", 64'(rd_resp_valid_out), 64'd0);
        check("rst_mid_init_done", 64'(init_done_out), 64'd0);
        @(negedge clk_in);
        reset_in = 1'b0;
        #1 check("resweep_set0", 64'(ram_write_set_addr_out), 64'd0);
        @(posedge clk_in); #1;
        check("resweep_set1", 64'(ram_write_set_addr_out), 64'd1);
        n = 1;
        while (!init_done_out && n < 200) begin
            @(posedge clk_in); #1; n++;
        end
        check("resweep_cycles", 64'(n), 64'd64);
        check("resweep_no_wr_resp", 64'(init_wr_resp_cnt), 64'd0);
        $display("re-sweep done after %0d cycles", n);

        @(negedge clk_in);
        rd_valid_in = 2'b01; rd_set_addr_in = {6'd0, 6'd7};
        #1 check("post_rst_grant", 64'(rd_ready_out), 64'd1);
        @(posedge clk_in); #1;
        rd_valid_in = 2'b00;
        check("post_rst_data", rd_resp_entry_out, 64'h0);
        $display("read set 7 after re-sweep data=%0h", rd_resp_entry_out);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
